cs_accum: RTL and testbench

CS_ACCUM -- requirements
Module: cs_accum

---
 rtl/cs_accum.sv | 126 ++++++++++++
 tb/tb_cs_accum.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cs_accum.sv
// Accumulator that sequences one command at a time through an external 12-bit adder.
// Define ACC_SATURATE_EN to clamp on add overflow or sub underflow instead of wrapping.
module cs_accum (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [11:0] i_data,
  output logic [11:0] o_add_a,
  output logic [11:0] o_add_b,
  output logic        o_add_cin,
  input  logic [11:0] i_add_sum,
  input  logic        i_add_cout,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [11:0] o_acc,
  output logic        o_ovf
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;
  typedef enum logic [1:0] {OpAdd = 2'b00, OpSub = 2'b01, OpLoad = 2'b10, OpClr = 2'b11} op_e;

  state_e      state_q, state_d;
  op_e         op_q;
  logic [11:0] data_q;
  logic [11:0] acc_q, acc_d;
  logic        ovf_q, ovf_d;
  logic        accept;
  logic        range_err;

  assign accept = i_valid && (state_q == StIdle);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StDone;
      StDone:  if (i_res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM and adder-interface outputs; adder inputs come only from registers
  always_comb begin
    o_ready     = (state_q == StIdle);
    o_res_valid = (state_q == StDone);
    o_add_a     = '0;
    o_add_b     = '0;
    o_add_cin   = 1'b0;
    if (state_q == StExec) begin
      o_add_a = acc_q;
      unique case (op_q)
        OpAdd:   o_add_b = data_q;
        OpSub: begin
          o_add_b   = ~data_q;
          o_add_cin = 1'b1;
        end
        default: o_add_b = '0;
      endcase
    end
  end

  // Accumulator and sticky flag update, applied only at the end of EXEC
  always_comb begin
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    range_err = 1'b0;
    if (state_q == StExec) begin
      unique case (op_q)
        OpAdd: begin
          range_err = i_add_cout;
          acc_d     = i_add_sum;
`ifdef ACC_SATURATE_EN
          if (range_err) acc_d = 12'hFFF;
`endif
        end
        OpSub: begin
          // a + ~b + 1 carries out exactly when a >= b, so no carry means underflow
          range_err = ~i_add_cout;
          acc_d     = i_add_sum;
`ifdef ACC_SATURATE_EN
          if (range_err) acc_d = 12'h000;
`endif
        end
        OpLoad: acc_d = data_q;
        OpClr: begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        default: acc_d = acc_q;
      endcase
      if (range_err) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q   <= OpAdd;
      data_q <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= op_e'(i_op);
        data_q <= i_data;
      end
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_acc = acc_q;
  assign o_ovf = ovf_q;

endmodule

// File: tb/tb_cs_accum.sv
// Bench for cs_accum: directed scenarios plus random commands against an arithmetic model.
// The external carry-select adder is modelled here as a plain 13-bit sum.
module tb_cs_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [1:0]  op;
  logic [11:0] data;
  logic [11:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        res_valid, res_ready;
  logic [11:0] acc;
  logic        ovf;

  int tests = 0;
  int fails = 0;
  int m_acc = 0;
  logic m_ovf = 1'b0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {12'd0, add_cin};

  cs_accum dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .o_ready     (ready),
    .i_op        (op),
    .i_data      (data),
    .o_add_a     (add_a),
    .o_add_b     (add_b),
    .o_add_cin   (add_cin),
    .i_add_sum   (add_sum),
    .i_add_cout  (add_cout),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_acc       (acc),
    .o_ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour computed with integer arithmetic
  task automatic model(input logic [1:0] c_op, input logic [11:0] c_data);
    int r;
    case (c_op)
      2'b00: begin
        r = m_acc + int'(c_data);
        if (r > 4095) begin
          m_ovf = 1'b1;
`ifdef ACC_SATURATE_EN
          r = 4095;
`endif
        end
        m_acc = r & 4095;
      end
      2'b01: begin
        r = m_acc - int'(c_data);
        if (r < 0) begin
          m_ovf = 1'b1;
`ifdef ACC_SATURATE_EN
          r = 0;
`endif
        end
        m_acc = r & 4095;
      end
      2'b10: m_acc = int'(c_data);
      default: begin
        m_acc = 0;
        m_ovf = 1'b0;
      end
    endcase
  endtask

  // Issue one command from IDLE at a negedge; returns at a negedge back in IDLE
  task automatic run_cmd(input logic [1:0] c_op, input logic [11:0] c_data, input int stall,
                         input bit pulse);
    logic [11:0] exp_b;
    check("ready_before", ready, 1);
    valid = 1'b1;
    op    = c_op;
    data  = c_data;
    @(negedge clk);
    valid = 1'b0;
    op    = $urandom_range(0, 3);
    data  = 12'($urandom);
    exp_b = (c_op == 2'b00) ? c_data : (c_op == 2'b01) ? ~c_data : 12'h000;
    check("exec_add_a", add_a, 32'(m_acc));
    check("exec_add_b", add_b, exp_b);
    check("exec_cin", add_cin, (c_op == 2'b01));
    check("exec_ready", ready, 0);
    check("exec_res_valid", res_valid, 0);
    model(c_op, c_data);
    @(negedge clk);
    check("done_res_valid", res_valid, 1);
    check("done_acc", acc, 32'(m_acc));
    check("done_ovf", ovf, m_ovf);
    check("done_add_b", add_b, 0);
    for (int i = 0; i < stall; i++) begin
      valid = pulse && (i % 2 == 0);
      @(negedge clk);
      check("stall_res_valid", res_valid, 1);
      check("stall_acc", acc, 32'(m_acc));
      check("stall_ready", ready, 0);
    end
    valid     = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("idle_ready", ready, 1);
    check("idle_res_valid", res_valid, 0);
    check("idle_acc", acc, 32'(m_acc));
  endtask

  initial begin
    int hits;
    int last_cyc;
    int stall;
    logic [1:0] r_op;

    rst_n     = 1'b0;
    valid     = 1'b0;
    op        = 2'b00;
    data      = 12'h000;
    res_ready = 1'b0;
    #1;
    check("rst_acc", acc, 0);
    check("rst_ovf", ovf, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_add_a", add_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", ready, 1);

    // Basic load/add
    run_cmd(2'b10, 12'h100, 0, 0);
    run_cmd(2'b00, 12'h0FF, 0, 0);
    check("sum_1ff", acc, 12'h1FF);
    check("sum_ovf0", ovf, 0);

    // Add overflow
    run_cmd(2'b10, 12'hFF0, 0, 0);
    run_cmd(2'b00, 12'h020, 0, 0);
    check("add_ovf", ovf, 1);
`ifdef ACC_SATURATE_EN
    check("add_ovf_acc", acc, 12'hFFF);
`else
    check("add_ovf_acc", acc, 12'h010);
`endif

    // Sub underflow, then clear
    run_cmd(2'b10, 12'h005, 0, 0);
    run_cmd(2'b01, 12'h007, 0, 0);
    check("sub_ovf", ovf, 1);
`ifdef ACC_SATURATE_EN
    check("sub_unf_acc", acc, 12'h000);
`else
    check("sub_unf_acc", acc, 12'hFFE);
`endif
    run_cmd(2'b11, 12'h123, 0, 0);
    check("clr_acc", acc, 0);
    check("clr_ovf", ovf, 0);

    // Consumer stall with ignored valid pulses
    run_cmd(2'b10, 12'h3A5, 5, 1);

    // Reset during EXEC
    run_cmd(2'b10, 12'h800, 0, 0);
    valid = 1'b1;
    op    = 2'b00;
    data  = 12'h001;
    @(negedge clk);
    valid = 1'b0;
    check("mid_exec_add_a", add_a, 12'h800);
    rst_n = 1'b0;
    #1;
    check("rst_exec_acc", acc, 0);
    check("rst_exec_res_valid", res_valid, 0);
    check("rst_exec_add_a", add_a, 0);
    check("rst_exec_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = 0;
    m_ovf = 1'b0;
    @(negedge clk);
    check("rst_exec_ready", ready, 1);
    check("rst_exec_res_valid2", res_valid, 0);
    check("rst_exec_acc2", acc, 0);

    // Back-to-back add 1 with valid and res_ready held
    valid     = 1'b1;
    op        = 2'b00;
    data      = 12'h001;
    res_ready = 1'b1;
    hits      = 0;
    last_cyc  = 0;
    for (int cyc = 1; cyc <= 20 && hits < 4; cyc++) begin
      @(negedge clk);
      if (res_valid) begin
        hits++;
        check("b2b_acc", acc, 32'(hits));
        if (hits > 1) check("b2b_spacing", 32'(cyc - last_cyc), 3);
        else check("b2b_latency", 32'(cyc), 2);
        last_cyc = cyc;
        if (hits == 4) valid = 1'b0;
      end
    end
    check("b2b_count", 32'(hits), 4);
    @(negedge clk);
    res_ready = 1'b0;
    check("b2b_idle", ready, 1);
    m_acc = 4;

    // Random commands; clear kept rare so values wander across the range
    for (int n = 0; n < 40; n++) begin
      r_op  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      stall = $urandom_range(0, 2);
      run_cmd(r_op, 12'($urandom), stall, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
